vehicle_sensor_filter: RTL and testbench
========================================

// Module: vehicle_sensor_filter
// PURPOSE
//   Conditions the raw side-street vehicle loop sensor for the traffic light controller.
//   Synchronises and debounces the sensor, and produces a clean vehicle-valid level (vv)
//   plus a one-cycle arrival strobe. Holds a service request and a saturating vehicle
//   count until the controller acknowledges service with req_clr.
//   Sits directly upstream of the controller FSM; vv feeds the controller's vv input.
// PARAMETERS
//   DEBOUNCE_CYCLES  16  consecutive stable synchronised samples required to change vv (>=2)
//   COUNT_W          8   width of veh_count; the count saturates at 2**COUNT_W-1
// PORTS
//   clk           in   1        system clock; all logic is on the rising edge
//   rst_n         in   1        asynchronous, active-low reset
//   sensor_raw    in   1        raw loop-sensor input; asynchronous and bouncy
//   req_clr       in   1        controller has served the side street; clears req and count
//   vv            out  1        debounced vehicle-present level
//   arrive_pulse  out  1        one-cycle strobe when vv rises
//   req           out  1        latched service request
//   veh_count     out  COUNT_W  arrivals since the last req_clr, saturating
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - All outputs are 0.
//     - Both synchroniser flops are 0, the FSM is in ABSENT, and the debounce counter is 0.
//   Synchroniser: two flops, sensor_raw -> s1 -> s2. Only s2 is used downstream.
//   Debounce FSM, with counter cnt of width $clog2(DEBOUNCE_CYCLES):
//     ABSENT:   s2=1 -> RISE_CHK, cnt=0.
//     RISE_CHK: s2=0 -> ABSENT (glitch rejected).
//               s2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESENT.
//               otherwise cnt++.
//     PRESENT:  s2=0 -> FALL_CHK, cnt=0.
//     FALL_CHK: s2=1 -> PRESENT (bounce rejected).
//               s2=0 and cnt==DEBOUNCE_CYCLES-1 -> ABSENT.
//               otherwise cnt++.
//   Outputs:
//     - vv = 1 in PRESENT and FALL_CHK; vv = 0 in ABSENT and RISE_CHK. vv is registered.
//     - arrive_pulse is 1 for exactly the cycle after the RISE_CHK->PRESENT transition,
//       i.e. the same cycle vv first reads 1.
//   Latency: sensor_raw is first sampled high at edge E; vv reads 1 after edge E+2+DEBOUNCE_CYCLES.
//     The fall path has the same latency.
//   req:
//     - Set by arrive_pulse; cleared by req_clr.
//     - If both occur in the same cycle, set wins and req stays 1.
//   veh_count:
//     - Increments by 1 on arrive_pulse and holds at all-ones (no wrap).
//     - req_clr loads 0.
//     - If req_clr and arrive_pulse coincide, veh_count loads 1.
//   req_clr while req=0 has no effect other than forcing veh_count to 0.
//   At most one arrival per debounced high period; the minimum arrival spacing is
//     2*DEBOUNCE_CYCLES+2 cycles.
//   rst_n low mid-debounce or mid-PRESENT aborts immediately to the reset state.
//     No arrive_pulse is produced on reset release, even if sensor_raw is high;
//     the full debounce applies again.
// TESTING (benches use DEBOUNCE_CYCLES=4, COUNT_W=2)
//   1. Clean pulse:
//      - sensor_raw high for 12 cycles.
//      - vv rises 6 edges after the first high sample; arrive_pulse is 1 for 1 cycle.
//      - req=1, veh_count=1; vv falls 6 edges after the first low sample.
//   2. Glitch: sensor_raw high for 3 cycles, then low -> vv, arrive_pulse, req and
//      veh_count all stay 0.
//   3. Bounce while present: after vv=1, drop sensor_raw low for 2 cycles, then high ->
//      vv stays 1, no second arrive_pulse, veh_count stays 1.
//   4. Saturation: 5 clean arrivals with no req_clr -> veh_count=3 after the 3rd arrival
//      and holds at 3; req stays 1.
//   5. Collision: req_clr asserted in the same cycle as arrive_pulse, with veh_count=2 ->
//      next cycle req=1, veh_count=1.
//   6. Async reset: assert rst_n low mid-PRESENT with no clock edge -> vv, req, veh_count
//      and arrive_pulse are 0 immediately; release with sensor_raw high -> vv rises only
//      after the full 6-cycle latency.

Source files
------------

// File: rtl/vehicle_sensor_filter.sv
// vehicle_sensor_filter
// Conditions the raw side-street loop sensor for the traffic light controller.
// The sensor is synchronised with two flops and then debounced by a four-state
// FSM. The FSM produces a clean vehicle-valid level and a one-cycle arrival
// strobe. A service request and a saturating arrival count are held until the
// controller acknowledges service with req_clr.

module vehicle_sensor_filter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sensor_raw,
  input  logic               req_clr,
  output logic               vv,
  output logic               arrive_pulse,
  output logic               req,
  output logic [COUNT_W-1:0] veh_count
);

  localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {
    ABSENT   = 2'd0,
    RISE_CHK = 2'd1,
    PRESENT  = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             vv_next;
  logic             arrive_next;

  // Two-flop synchroniser; only s2 is safe to use downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sensor_raw;
      s2 <= s1;
    end
  end

  // Debounce state, counter and the registered vv/arrive outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ABSENT;
      cnt          <= '0;
      vv           <= 1'b0;
      arrive_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      vv           <= vv_next;
      arrive_pulse <= arrive_next;
    end
  end

  // Next-state logic. vv follows the next state so that it changes on the
  // same edge as the state, and arrive fires only on a confirmed rise.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    arrive_next = 1'b0;
    unique case (state)
      ABSENT: begin
        if (s2) begin
          state_next = RISE_CHK;
          cnt_next   = '0;
        end
      end
      RISE_CHK: begin
        if (!s2) begin
          state_next = ABSENT;
        end else if (cnt == CNT_LAST) begin
          state_next  = PRESENT;
          arrive_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESENT: begin
        if (!s2) begin
          state_next = FALL_CHK;
          cnt_next   = '0;
        end
      end
      FALL_CHK: begin
        if (s2) begin
          state_next = PRESENT;
        end else if (cnt == CNT_LAST) begin
          state_next = ABSENT;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ABSENT;
        cnt_next   = '0;
      end
    endcase
    vv_next = (state_next == PRESENT) || (state_next == FALL_CHK);
  end

  // Service request: a new arrival wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= 1'b0;
    end else if (arrive_pulse) begin
      req <= 1'b1;
    end else if (req_clr) begin
      req <= 1'b0;
    end
  end

  // Saturating arrival count; a clear together with an arrival leaves one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      veh_count <= '0;
    end else if (req_clr) begin
      veh_count <= arrive_pulse ? COUNT_W'(1) : '0;
    end else if (arrive_pulse && (veh_count != COUNT_MAX)) begin
      veh_count <= veh_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_vehicle_sensor_filter.sv
// tb_vehicle_sensor_filter
// Directed bench for vehicle_sensor_filter with DEBOUNCE_CYCLES=4, COUNT_W=2.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.

module tb_vehicle_sensor_filter;

  logic       clk;
  logic       rst_n;
  logic       sensor_raw;
  logic       req_clr;
  logic       vv;
  logic       arrive_pulse;
  logic       req;
  logic [1:0] veh_count;

  int vectors;
  int miscompares;
  int exp_count;

  vehicle_sensor_filter #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sensor_raw(sensor_raw),
    .req_clr(req_clr),
    .vv(vv),
    .arrive_pulse(arrive_pulse),
    .req(req),
    .veh_count(veh_count)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_count   = 0;
    rst_n       = 1'b0;
    sensor_raw  = 1'b0;
    req_clr     = 1'b0;

    // Reset state.
    #12;
    checkOutput("reset_vv", {7'd0, vv}, 8'd0);
    checkOutput("reset_arrive", {7'd0, arrive_pulse}, 8'd0);
    checkOutput("reset_req", {7'd0, req}, 8'd0);
    checkOutput("reset_count", {6'd0, veh_count}, 8'd0);
    applyStimulus(1);
    rst_n = 1'b1;
    applyStimulus(2);

    // 1. Clean pulse: 12 cycles high, 6-edge latency in each direction.
    $display("[TB] clean pulse");
    sensor_raw = 1'b1;
    applyStimulus(6);
    checkOutput("clean_vv_before", {7'd0, vv}, 8'd0);
    applyStimulus(1);
    checkOutput("clean_vv_rise", {7'd0, vv}, 8'd1);
    checkOutput("clean_arrive", {7'd0, arrive_pulse}, 8'd1);
    applyStimulus(1);
    checkOutput("clean_arrive_once", {7'd0, arrive_pulse}, 8'd0);
    checkOutput("clean_req", {7'd0, req}, 8'd1);
    checkOutput("clean_count", {6'd0, veh_count}, 8'd1);
    applyStimulus(4);
    sensor_raw = 1'b0;
    applyStimulus(6);
    checkOutput("clean_vv_hold", {7'd0, vv}, 8'd1);
    applyStimulus(1);
    checkOutput("clean_vv_fall", {7'd0, vv}, 8'd0);
    req_clr = 1'b1;
    applyStimulus(1);
    req_clr = 1'b0;
    checkOutput("clr_req", {7'd0, req}, 8'd0);
    checkOutput("clr_count", {6'd0, veh_count}, 8'd0);

    // 2. Glitch of 3 cycles is rejected.
    $display("[TB] glitch");
    sensor_raw = 1'b1;
    applyStimulus(3);
    sensor_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput("glitch_vv", {7'd0, vv}, 8'd0);
      checkOutput("glitch_arrive", {7'd0, arrive_pulse}, 8'd0);
    end
    checkOutput("glitch_req", {7'd0, req}, 8'd0);
    checkOutput("glitch_count", {6'd0, veh_count}, 8'd0);

    // 3. Short dropout while present is absorbed.
    $display("[TB] bounce while present");
    sensor_raw = 1'b1;
    applyStimulus(7);
    checkOutput("bounce_vv_rise", {7'd0, vv}, 8'd1);
    applyStimulus(1);
    sensor_raw = 1'b0;
    applyStimulus(2);
    sensor_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput("bounce_vv", {7'd0, vv}, 8'd1);
      checkOutput("bounce_arrive", {7'd0, arrive_pulse}, 8'd0);
    end
    checkOutput("bounce_count", {6'd0, veh_count}, 8'd1);
    sensor_raw = 1'b0;
    applyStimulus(7);
    checkOutput("bounce_vv_fall", {7'd0, vv}, 8'd0);

    // 4. Saturation over five arrivals without a clear.
    $display("[TB] saturation");
    req_clr = 1'b1;
    applyStimulus(1);
    req_clr = 1'b0;
    exp_count = 0;
    for (int i = 0; i < 5; i++) begin
      sensor_raw = 1'b1;
      applyStimulus(8);
      exp_count = (exp_count == 3) ? 3 : exp_count + 1;
      checkOutput("sat_count", {6'd0, veh_count}, 8'(exp_count));
      checkOutput("sat_req", {7'd0, req}, 8'd1);
      sensor_raw = 1'b0;
      applyStimulus(8);
    end

    // 5. Clear coinciding with an arrival while the count is 2.
    $display("[TB] collision");
    req_clr = 1'b1;
    applyStimulus(1);
    req_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sensor_raw = 1'b1;
      applyStimulus(8);
      sensor_raw = 1'b0;
      applyStimulus(8);
    end
    checkOutput("coll_count_pre", {6'd0, veh_count}, 8'd2);
    sensor_raw = 1'b1;
    applyStimulus(7);
    checkOutput("coll_arrive", {7'd0, arrive_pulse}, 8'd1);
    req_clr = 1'b1;
    applyStimulus(1);
    req_clr = 1'b0;
    checkOutput("coll_req", {7'd0, req}, 8'd1);
    checkOutput("coll_count", {6'd0, veh_count}, 8'd1);

    // 6. Asynchronous reset while present, released with the sensor high.
    $display("[TB] async reset");
    applyStimulus(2);
    checkOutput("areset_vv_pre", {7'd0, vv}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_vv", {7'd0, vv}, 8'd0);
    checkOutput("areset_req", {7'd0, req}, 8'd0);
    checkOutput("areset_count", {6'd0, veh_count}, 8'd0);
    checkOutput("areset_arrive", {7'd0, arrive_pulse}, 8'd0);
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("release_arrive", {7'd0, arrive_pulse}, 8'd0);
    applyStimulus(5);
    checkOutput("release_vv_before", {7'd0, vv}, 8'd0);
    applyStimulus(1);
    checkOutput("release_vv_rise", {7'd0, vv}, 8'd1);
    checkOutput("release_arrive_rise", {7'd0, arrive_pulse}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
